// File: rtl/bubbledrive8_input_conditioner.sv
// Board status input conditioner: synchronises, debounces and normalises
// the power status lines and the active-low DIP banks for the startup FSM.

module bubbledrive8_ic_chan #(
  parameter int             W               = 1,
  parameter int             SYNC_STAGES     = 2,
  parameter int             DEBOUNCE_CYCLES = 48000,
  parameter int             CNT_W           = 16,
  parameter logic [W-1:0]   RST_VAL         = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_cand,
  output logic         o_sat,
  output logic         o_valid,
  output logic         o_hit
);

  localparam logic [CNT_W-1:0] N_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][W-1:0] r_sync;
  logic [W-1:0]                  r_cand;
  logic [CNT_W-1:0]              r_cnt;
  logic                          r_valid;

  logic [W-1:0] w_s;
  logic         w_same;
  logic         w_sat;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_same = (w_s == r_cand);
  assign w_sat  = (r_cnt == N_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= {SYNC_STAGES{RST_VAL}};
      r_cand  <= RST_VAL;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      // any difference restarts the hold window from zero
      if (!w_same) begin
        r_cand <= w_s;
        r_cnt  <= '0;
      end else if (!w_sat) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_valid <= 1'b1;
      end
    end
  end

  assign o_cand  = r_cand;
  assign o_sat   = w_sat;
  assign o_valid = r_valid;
  assign o_hit   = w_same & w_sat;

endmodule

module bubbledrive8_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 48000,
  parameter int CNT_W           = 16
) (
  input  logic       MCLK,
  input  logic       nRST,
  input  logic       MRST_RAW,
  input  logic       PWRSTAT_RAW,
  input  logic [3:0] SETTINGSW_RAW,
  input  logic [1:0] DELAYSW_RAW,
  input  logic [3:0] IMGSELSW_RAW,
  input  logic       LOCK,
  output logic       MRST_DB,
  output logic       PWRSTAT_DB,
  output logic [9:0] SETTINGS,
  output logic       STABLE,
  output logic       PWRCHG,
  output logic       SWCHG
);

  logic       w_a_cand, w_a_sat, w_a_valid, w_a_hit;
  logic       w_b_cand, w_b_sat, w_b_valid, w_b_hit;
  logic [9:0] w_c_cand;
  logic       w_c_sat, w_c_valid, w_c_hit;
  logic [9:0] w_c_raw;
  logic       w_a_chg, w_b_chg, w_c_chg, w_c_acc;

  logic       r_mrst, r_pwr, r_stable, r_pwrchg, r_swchg;
  logic [9:0] r_set;

  assign w_c_raw = {SETTINGSW_RAW, DELAYSW_RAW, IMGSELSW_RAW};

  bubbledrive8_ic_chan #(
    .W(1), .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W),
    .RST_VAL(1'b1)
  ) u_a (
    .i_clk(MCLK), .i_rst_n(nRST), .i_raw(MRST_RAW),
    .o_cand(w_a_cand), .o_sat(w_a_sat),
    .o_valid(w_a_valid), .o_hit(w_a_hit)
  );

  bubbledrive8_ic_chan #(
    .W(1), .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W),
    .RST_VAL(1'b0)
  ) u_b (
    .i_clk(MCLK), .i_rst_n(nRST), .i_raw(PWRSTAT_RAW),
    .o_cand(w_b_cand), .o_sat(w_b_sat),
    .o_valid(w_b_valid), .o_hit(w_b_hit)
  );

  bubbledrive8_ic_chan #(
    .W(10), .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W),
    .RST_VAL(10'h3FF)
  ) u_c (
    .i_clk(MCLK), .i_rst_n(nRST), .i_raw(w_c_raw),
    .o_cand(w_c_cand), .o_sat(w_c_sat),
    .o_valid(w_c_valid), .o_hit(w_c_hit)
  );

  // change pulses only once a channel has been accepted before
  assign w_c_acc = w_c_hit & ~LOCK;
  assign w_a_chg = w_a_hit & w_a_valid & (w_a_cand != r_mrst);
  assign w_b_chg = w_b_hit & w_b_valid & (w_b_cand != r_pwr);
  assign w_c_chg = w_c_acc & w_c_valid & (~w_c_cand != r_set);

  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      r_mrst   <= 1'b1;
      r_pwr    <= 1'b0;
      r_set    <= 10'h000;
      r_stable <= 1'b0;
      r_pwrchg <= 1'b0;
      r_swchg  <= 1'b0;
    end else begin
      if (w_a_hit) r_mrst <= w_a_cand;
      if (w_b_hit) r_pwr  <= w_b_cand;
      if (w_c_acc) r_set  <= ~w_c_cand;
      r_pwrchg <= w_a_chg | w_b_chg;
      r_swchg  <= w_c_chg;
      r_stable <= w_a_valid & w_b_valid & w_c_valid
                & w_a_sat & w_b_sat & w_c_sat;
    end
  end

  assign MRST_DB    = r_mrst;
  assign PWRSTAT_DB = r_pwr;
  assign SETTINGS   = r_set;
  assign STABLE     = r_stable;
  assign PWRCHG     = r_pwrchg;
  assign SWCHG      = r_swchg;

endmodule

// File: tb/tb_bubbledrive8_input_conditioner.sv
// Directed vector bench for bubbledrive8_input_conditioner
// with short debounce (SYNC_STAGES=2, DEBOUNCE_CYCLES=8).

module tb_bubbledrive8_input_conditioner;

  logic       MCLK;
  logic       nRST;
  logic       MRST_RAW, PWRSTAT_RAW, LOCK;
  logic [3:0] SETTINGSW_RAW, IMGSELSW_RAW;
  logic [1:0] DELAYSW_RAW;
  logic       MRST_DB, PWRSTAT_DB, STABLE, PWRCHG, SWCHG;
  logic [9:0] SETTINGS;

  int n_pass = 0;
  int n_tot  = 0;
  int n_pc   = 0;
  int n_sc   = 0;

  typedef struct {
    string      nm;
    logic       mrst;
    logic       pwr;
    logic [3:0] sw;
    logic [1:0] dly;
    logic [3:0] img;
    logic       lock;
    int         cyc;
    logic       e_mrst;
    logic       e_pwr;
    logic [9:0] e_set;
    logic       e_stb;
    int         e_pc;
    int         e_sc;
  } vt_t;

  vt_t vecs[$];

  bubbledrive8_input_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .CNT_W(4)
  ) dut (
    .MCLK(MCLK), .nRST(nRST),
    .MRST_RAW(MRST_RAW), .PWRSTAT_RAW(PWRSTAT_RAW),
    .SETTINGSW_RAW(SETTINGSW_RAW), .DELAYSW_RAW(DELAYSW_RAW),
    .IMGSELSW_RAW(IMGSELSW_RAW), .LOCK(LOCK),
    .MRST_DB(MRST_DB), .PWRSTAT_DB(PWRSTAT_DB),
    .SETTINGS(SETTINGS), .STABLE(STABLE),
    .PWRCHG(PWRCHG), .SWCHG(SWCHG)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  function automatic vt_t mk(
    string nm, logic mrst, logic pwr, logic [3:0] sw,
    logic [1:0] dly, logic [3:0] img, logic lock, int cyc,
    logic e_mrst, logic e_pwr, logic [9:0] e_set,
    logic e_stb, int e_pc, int e_sc);
    vt_t v;
    v.nm = nm; v.mrst = mrst; v.pwr = pwr; v.sw = sw;
    v.dly = dly; v.img = img; v.lock = lock; v.cyc = cyc;
    v.e_mrst = e_mrst; v.e_pwr = e_pwr; v.e_set = e_set;
    v.e_stb = e_stb; v.e_pc = e_pc; v.e_sc = e_sc;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge MCLK);
      #1;
      if (PWRCHG) n_pc++;
      if (SWCHG)  n_sc++;
    end
  endtask

  task automatic drive(logic m, logic p, logic [3:0] s,
                       logic [1:0] d, logic [3:0] i, logic l);
    MRST_RAW = m; PWRSTAT_RAW = p; SETTINGSW_RAW = s;
    DELAYSW_RAW = d; IMGSELSW_RAW = i; LOCK = l;
  endtask

  task automatic chk_outs(string nm, logic m, logic p,
                          logic [9:0] s, logic st);
    chk({nm, ".mrst"},   32'(MRST_DB),    32'(m));
    chk({nm, ".pwr"},    32'(PWRSTAT_DB), 32'(p));
    chk({nm, ".set"},    32'(SETTINGS),   32'(s));
    chk({nm, ".stable"}, 32'(STABLE),     32'(st));
  endtask

  initial begin
    vecs.push_back(mk("init_wait",  1'b0,1'b0,4'hF,2'h3,4'hF,1'b0,10, 1'b1,1'b0,10'h000,1'b0,0,0));
    vecs.push_back(mk("init_acc",   1'b0,1'b0,4'hF,2'h3,4'hF,1'b0, 1, 1'b0,1'b0,10'h000,1'b0,0,0));
    vecs.push_back(mk("init_stb",   1'b0,1'b0,4'hF,2'h3,4'hF,1'b0, 1, 1'b0,1'b0,10'h000,1'b1,0,0));
    vecs.push_back(mk("glitch_hi",  1'b1,1'b0,4'hF,2'h3,4'hF,1'b0, 5, 1'b0,1'b0,10'h000,1'b0,0,0));
    vecs.push_back(mk("glitch_lo",  1'b0,1'b0,4'hF,2'h3,4'hF,1'b0,10, 1'b0,1'b0,10'h000,1'b0,0,0));
    vecs.push_back(mk("glitch_rec", 1'b0,1'b0,4'hF,2'h3,4'hF,1'b0, 1, 1'b0,1'b0,10'h000,1'b1,0,0));
    vecs.push_back(mk("mrst_wait",  1'b1,1'b0,4'hF,2'h3,4'hF,1'b0,10, 1'b0,1'b0,10'h000,1'b0,0,0));
    vecs.push_back(mk("mrst_acc",   1'b1,1'b0,4'hF,2'h3,4'hF,1'b0, 1, 1'b1,1'b0,10'h000,1'b1,1,0));
    vecs.push_back(mk("mrst_hold",  1'b1,1'b0,4'hF,2'h3,4'hF,1'b0, 9, 1'b1,1'b0,10'h000,1'b1,0,0));
    vecs.push_back(mk("img_wait",   1'b1,1'b0,4'hF,2'h3,4'hA,1'b0,10, 1'b1,1'b0,10'h000,1'b0,0,0));
    vecs.push_back(mk("img_acc",    1'b1,1'b0,4'hF,2'h3,4'hA,1'b0, 1, 1'b1,1'b0,10'h005,1'b1,0,1));
    vecs.push_back(mk("img_hold",   1'b1,1'b0,4'hF,2'h3,4'hA,1'b0, 1, 1'b1,1'b0,10'h005,1'b1,0,0));
    vecs.push_back(mk("tog0",       1'b1,1'b0,4'hF,2'h2,4'hA,1'b0, 3, 1'b1,1'b0,10'h005,1'b1,0,0));
    vecs.push_back(mk("tog1",       1'b1,1'b0,4'hF,2'h3,4'hA,1'b0, 3, 1'b1,1'b0,10'h005,1'b0,0,0));
    vecs.push_back(mk("tog2",       1'b1,1'b0,4'hF,2'h2,4'hA,1'b0, 3, 1'b1,1'b0,10'h005,1'b0,0,0));
    vecs.push_back(mk("tog3",       1'b1,1'b0,4'hF,2'h3,4'hA,1'b0, 3, 1'b1,1'b0,10'h005,1'b0,0,0));
    vecs.push_back(mk("tog_settle", 1'b1,1'b0,4'hF,2'h3,4'hA,1'b0, 7, 1'b1,1'b0,10'h005,1'b0,0,0));
    vecs.push_back(mk("tog_rec",    1'b1,1'b0,4'hF,2'h3,4'hA,1'b0, 1, 1'b1,1'b0,10'h005,1'b1,0,0));
    vecs.push_back(mk("lock_wait",  1'b1,1'b0,4'h7,2'h3,4'hA,1'b1,10, 1'b1,1'b0,10'h005,1'b0,0,0));
    vecs.push_back(mk("lock_sat",   1'b1,1'b0,4'h7,2'h3,4'hA,1'b1, 1, 1'b1,1'b0,10'h005,1'b1,0,0));
    vecs.push_back(mk("lock_hold",  1'b1,1'b0,4'h7,2'h3,4'hA,1'b1, 3, 1'b1,1'b0,10'h005,1'b1,0,0));
    vecs.push_back(mk("unlock",     1'b1,1'b0,4'h7,2'h3,4'hA,1'b0, 1, 1'b1,1'b0,10'h205,1'b1,0,1));
    vecs.push_back(mk("unlock_hold",1'b1,1'b0,4'h7,2'h3,4'hA,1'b0, 1, 1'b1,1'b0,10'h205,1'b1,0,0));
    vecs.push_back(mk("dual_wait",  1'b0,1'b1,4'h7,2'h3,4'hA,1'b0,10, 1'b1,1'b0,10'h205,1'b0,0,0));
    vecs.push_back(mk("dual_acc",   1'b0,1'b1,4'h7,2'h3,4'hA,1'b0, 1, 1'b0,1'b1,10'h205,1'b1,1,0));
    vecs.push_back(mk("dual_hold",  1'b0,1'b1,4'h7,2'h3,4'hA,1'b0, 2, 1'b0,1'b1,10'h205,1'b1,0,0));

    nRST = 1'b0;
    drive(1'b0, 1'b0, 4'hF, 2'h3, 4'hF, 1'b0);
    repeat (2) @(posedge MCLK);
    #1;
    chk_outs("reset", 1'b1, 1'b0, 10'h000, 1'b0);
    chk("reset.pwrchg", 32'(PWRCHG), 0);
    chk("reset.swchg",  32'(SWCHG),  0);
    nRST = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].mrst, vecs[k].pwr, vecs[k].sw,
            vecs[k].dly, vecs[k].img, vecs[k].lock);
      n_pc = 0;
      n_sc = 0;
      tick(vecs[k].cyc);
      chk_outs(vecs[k].nm, vecs[k].e_mrst, vecs[k].e_pwr,
               vecs[k].e_set, vecs[k].e_stb);
      chk({vecs[k].nm, ".pwrchg_cnt"}, n_pc, vecs[k].e_pc);
      chk({vecs[k].nm, ".swchg_cnt"},  n_sc, vecs[k].e_sc);
    end

    // reset asserted while PWRSTAT counter sits at 4
    drive(1'b0, 1'b0, 4'h7, 2'h3, 4'hA, 1'b0);
    tick(7);
    chk("midcnt.pwr_pending", 32'(PWRSTAT_DB), 1);
    chk("midcnt.set_pending", 32'(SETTINGS),   32'h205);
    nRST = 1'b0;
    #1;
    chk_outs("async_rst", 1'b1, 1'b0, 10'h000, 1'b0);
    chk("async_rst.pwrchg", 32'(PWRCHG), 0);
    chk("async_rst.swchg",  32'(SWCHG),  0);
    #2;
    nRST = 1'b1;
    n_pc = 0;
    n_sc = 0;
    tick(10);
    chk_outs("rerun_wait", 1'b1, 1'b0, 10'h000, 1'b0);
    tick(1);
    chk_outs("rerun_acc", 1'b0, 1'b0, 10'h205, 1'b0);
    tick(1);
    chk("rerun_stb.stable", 32'(STABLE), 1);
    chk("rerun.pwrchg_cnt", n_pc, 0);
    chk("rerun.swchg_cnt",  n_sc, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
